// File: rtl/pred_scoreboard_pkg.sv
// Shared definitions for the BlackWidow predicate path.
//
// Contents:
//   NPRED / CNTW / PRW : predicate count, pending-counter width, register number width
//   PRED_ZERO/PRED_ONE : hardwired constant predicates (p0 reads 0, p1 reads 1)
//   pregno_t           : predicate register number
//   fwd_sel_t          : forward-mux select for the issue-stage predicate source
//   is_const_pred()    : true for p0/p1, which are never stored, counted or stalled on
package rfBlackWidowPkg;

  localparam int NPRED = 64;
  localparam int CNTW  = 2;
  localparam int PRW   = $clog2(NPRED);

  typedef logic [5:0] pregno_t;

  localparam pregno_t PRED_ZERO = 6'd0;
  localparam pregno_t PRED_ONE  = 6'd1;

  typedef enum logic [1:0] {
    FWD_CONST = 2'd0,
    FWD_X     = 2'd1,
    FWD_W     = 2'd2,
    FWD_RF    = 2'd3
  } fwd_sel_t;

  function automatic logic is_const_pred(input pregno_t r);
    return (r == PRED_ZERO) || (r == PRED_ONE);
  endfunction

endpackage

// File: rtl/pred_scoreboard_pend_cnt.sv
// Per-register pending-writer counter.
//
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset (clears count)
//   inc           : one more writer issued to this register
//   dec           : one writer retired from this register
//   clr           : discard all pending writers (flush); wins over inc/dec
//   cnt           : registered count
//   cnt_nxt       : value cnt takes at the next edge (used for a registered busy flag)
//
// inc and dec together cancel. Decrement at zero holds zero and increment at
// the maximum holds the maximum; the issue stall keeps the latter from happening.
module pred_pend_cnt
  import rfBlackWidowPkg::*;
#(
  parameter int W = CNTW
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc,
  input  logic         dec,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic [W-1:0] cnt_nxt
);

  always_comb begin
    cnt_nxt = cnt;
    if (clr) begin
      cnt_nxt = '0;
    end else if (inc && !dec && (cnt != {W{1'b1}})) begin
      cnt_nxt = cnt + 1'b1;
    end else if (dec && !inc && (cnt != '0)) begin
      cnt_nxt = cnt - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/pred_scoreboard.sv
// Predicate register file and hazard controller for the BlackWidow predicate path.
//
// 64 one-bit predicates; p0 reads 0, p1 reads 1 and neither is ever written or
// tracked. Every predicate writer writes a true/complement pair (pRt1 gets the
// result, pRt2 its complement). A per-register counter tracks writers between
// issue and writeback so the issue stage can be stalled on unresolved hazards.
//
// Handshake: an issue is accepted on a rising clk_i edge when iss_v_i and
// iss_rdy_o are both high. iss_rdy_o never looks at iss_v_i, so the issue
// stage may sample it before deciding to present an instruction.
//
// Ports:
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   flush_i                  : drop all in-flight writers (counters clear next edge)
//   iss_v_i                  : issue-stage instruction valid
//   iss_pRn_i                : source predicate being read at issue
//   iss_pRt1_i, iss_pRt2_i   : destinations of the issuing instruction
//   iss_prfwr_i              : issuing instruction writes predicates
//   iss_rdy_o                : issue may proceed this cycle
//   xpRt1_i, xpRt2_i, xprfwr_i           : execute-stage predicate write
//   wpRt1_i, wpRt2_i, wprfwr_i, wpres_i  : writeback predicate write and result
//   fwd_sel_o                : forward select for iss_pRn_i (CONST / X / W / RF)
//   prfo_o                   : register-file value of iss_pRn_i (no bypass)
//   busy_o                   : registered "some writer is still pending"
module pred_scoreboard
  import rfBlackWidowPkg::*;
(
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           flush_i,
  input  logic           iss_v_i,
  input  logic [PRW-1:0] iss_pRn_i,
  input  logic [PRW-1:0] iss_pRt1_i,
  input  logic [PRW-1:0] iss_pRt2_i,
  input  logic           iss_prfwr_i,
  output logic           iss_rdy_o,
  input  logic [PRW-1:0] xpRt1_i,
  input  logic [PRW-1:0] xpRt2_i,
  input  logic           xprfwr_i,
  input  logic [PRW-1:0] wpRt1_i,
  input  logic [PRW-1:0] wpRt2_i,
  input  logic           wprfwr_i,
  input  logic           wpres_i,
  output logic [1:0]     fwd_sel_o,
  output logic           prfo_o,
  output logic           busy_o
);

  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  // Counters and their next values; slots 0/1 are constant zero.
  logic [NPRED-1:0][CNTW-1:0] cnt_q;
  logic [NPRED-1:0][CNTW-1:0] cnt_d;
  logic [NPRED-1:2]           inc_vec;
  logic [NPRED-1:2]           dec_vec;

  // Stored predicates p2..p63; p0/p1 are spliced in as constants on read.
  logic [NPRED-1:2] p_q;
  logic [NPRED-1:0] p_all;

  logic           accept;
  logic           cnt_en;
  logic [CNTW-1:0] cnt_rn;
  logic           x_hit;
  logic           w_hit;
  logic           src_haz;
  logic           dst_haz;
  logic           busy_q;
  fwd_sel_t       fwd_sel;

  assign accept = iss_v_i & iss_rdy_o;
  // A writer accepted during a flush belongs to the flushed stream.
  assign cnt_en = accept & iss_prfwr_i & ~flush_i;

  // Matching each slot against both destinations also de-duplicates pRt1==pRt2.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int r = 2; r < NPRED; r++) begin
      inc_vec[r] = cnt_en &
                   ((iss_pRt1_i == PRW'(r)) || (iss_pRt2_i == PRW'(r)));
      dec_vec[r] = wprfwr_i &
                   ((wpRt1_i == PRW'(r)) || (wpRt2_i == PRW'(r)));
    end
  end

  assign cnt_q[1:0] = '0;
  assign cnt_d[1:0] = '0;

  for (genvar r = 2; r < NPRED; r++) begin : g_cnt
    pred_pend_cnt #(.W(CNTW)) u_cnt (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .inc     (inc_vec[r]),
      .dec     (dec_vec[r]),
      .clr     (flush_i),
      .cnt     (cnt_q[r]),
      .cnt_nxt (cnt_d[r])
    );
  end

  // Predicate storage. pRt1 is tested first so it wins when both name one register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      p_q <= '0;
    end else if (wprfwr_i) begin
      for (int r = 2; r < NPRED; r++) begin
        if (wpRt1_i == PRW'(r)) begin
          p_q[r] <= wpres_i;
        end else if (wpRt2_i == PRW'(r)) begin
          p_q[r] <= ~wpres_i;
        end
      end
    end
  end

  assign p_all  = {p_q, 1'b1, 1'b0};
  assign prfo_o = p_all[iss_pRn_i];

  // Source-side match against in-flight producers.
  assign x_hit = xprfwr_i & ((iss_pRn_i == xpRt1_i) || (iss_pRn_i == xpRt2_i));
  assign w_hit = wprfwr_i & ((iss_pRn_i == wpRt1_i) || (iss_pRn_i == wpRt2_i));

  assign cnt_rn = cnt_q[iss_pRn_i];

  // One pending writer can be forwarded if it is sitting in X or W right now;
  // two or more means the youngest is still upstream of X and has no value yet.
  always_comb begin
    src_haz = 1'b0;
    if (!is_const_pred(iss_pRn_i)) begin
      if (cnt_rn >= CNTW'(2)) begin
        src_haz = 1'b1;
      end else if ((cnt_rn == CNTW'(1)) && !x_hit && !w_hit) begin
        src_haz = 1'b1;
      end
    end
  end

  // Structural: a full counter cannot take another writer. A retire in the
  // same cycle is deliberately not credited, which keeps this path short.
  always_comb begin
    dst_haz = 1'b0;
    if (iss_prfwr_i) begin
      if (!is_const_pred(iss_pRt1_i) && (cnt_q[iss_pRt1_i] == CNT_MAX)) begin
        dst_haz = 1'b1;
      end
      if (!is_const_pred(iss_pRt2_i) && (cnt_q[iss_pRt2_i] == CNT_MAX)) begin
        dst_haz = 1'b1;
      end
    end
  end

  assign iss_rdy_o = ~(src_haz | dst_haz);

  always_comb begin
    fwd_sel = FWD_RF;
    if (is_const_pred(iss_pRn_i)) begin
      fwd_sel = FWD_CONST;
    end else if (x_hit) begin
      fwd_sel = FWD_X;
    end else if (w_hit) begin
      fwd_sel = FWD_W;
    end
  end

  assign fwd_sel_o = fwd_sel;

  // Registered from next counter values so it tracks the counters cycle-for-cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= 1'b0;
    end else begin
      busy_q <= |cnt_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: doc/pred_scoreboard.md
Name: pred_scoreboard

Overview:
Predicate register file and hazard controller for the BlackWidow predicate path: 64 one-bit predicates, p0 hardwired 0, p1 hardwired 1.
- Tracks in-flight predicate writers between issue and writeback.
- Stalls issue on unresolved predicate hazards.
- Produces the forwarding select and the register-file value consumed by the predicate forward mux.
- Sits beside the issue stage. Executes and writebacks write a true/complement pair (pRt1 receives the result, pRt2 its complement).

Parameters:
NPRED, 64, number of predicate registers (register number width = $clog2(NPRED) = 6)
CNTW, 2, width of per-register pending-writer counter (max 3 outstanding)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  pipeline flush; discard all in-flight writers
iss_v_i  in  1  issue-stage instruction valid
iss_pRn_i  in  6  source predicate register
iss_pRt1_i  in  6  destination (true) predicate
iss_pRt2_i  in  6  destination (complement) predicate
iss_prfwr_i  in  1  issuing instruction writes predicates
iss_rdy_o  out  1  issue may proceed this cycle
xpRt1_i  in  6  execute-stage destination (true)
xpRt2_i  in  6  execute-stage destination (complement)
xprfwr_i  in  1  execute stage writing predicates
wpRt1_i  in  6  writeback destination (true)
wpRt2_i  in  6  writeback destination (complement)
wprfwr_i  in  1  writeback writing predicates
wpres_i  in  1  writeback result
fwd_sel_o  out  2  forward select for iss_pRn_i: CONST / X / W / RF
prfo_o  out  1  register-file value of iss_pRn_i
busy_o  out  1  any pending counter nonzero

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low on rst_ni. Reset clears all counters and all predicate bits to 0.
- Reset output values: iss_rdy_o=1, busy_o=0, prfo_o=0 (and 1 when iss_pRn_i=1), fwd_sel_o=CONST when iss_pRn_i<2, else RF.
- Accept: accept = iss_v_i & iss_rdy_o.
- Storage write: on wprfwr_i, p[wpRt1_i]<=wpres_i and p[wpRt2_i]<=~wpres_i at the next edge. Writes to p0/p1 are ignored. If wpRt1_i==wpRt2_i, the pRt1 write wins.
- Storage read: prfo_o is a combinational read of p[iss_pRn_i]; p0 reads 0, p1 reads 1. A same-cycle writeback is not bypassed here; that case is covered by fwd_sel_o=W.
- Counters, increment: on accept & iss_prfwr_i, cnt[iss_pRt1_i]++ and cnt[iss_pRt2_i]++. Registers 0/1 are never counted. When both destinations are the same register, increment once.
- Counters, decrement: on wprfwr_i, cnt[wpRt1_i]-- and cnt[wpRt2_i]--, with the same de-duplication and p0/p1 exclusion. Simultaneous increment and decrement on one register gives net 0. Decrement at 0 holds 0 (protocol error, no wrap).
- Stall (iss_rdy_o=0) when any of the following holds:
  - iss_pRn_i>=2 and cnt[pRn]>=2.
  - iss_pRn_i>=2 and cnt[pRn]==1, with neither an X match (xprfwr_i & pRn in {xpRt1_i,xpRt2_i}) nor a W match.
  - iss_prfwr_i and a destination >=2 has cnt==3 (structural; the counter never saturates past 3).
- iss_rdy_o is combinational from registered counters plus X/W inputs. It does not depend on iss_v_i.
- fwd_sel_o priority:
  - CONST if iss_pRn_i<2.
  - Else X if xprfwr_i and pRn matches xpRt1_i/xpRt2_i.
  - Else W if wprfwr_i and pRn matches wpRt1_i/wpRt2_i.
  - Else RF.
- Flush: synchronous. All counters are 0 at the next edge. An issue accepted in the flush cycle is not counted. A writeback in the flush cycle still updates storage. iss_rdy_o is unaffected in the flush cycle.
- Reset mid-operation: all pending state is lost immediately. The pipeline must be reset together with this block.
- busy_o: registered OR-reduce of counters. It is 0 the cycle after flush or after the last retire.

Decomposition:
- Shared package rfBlackWidowPkg gets:
  - NPRED.
  - PRED_ZERO=0 and PRED_ONE=1.
  - typedef pregno_t (logic [5:0]).
  - enum fwd_sel_t {FWD_CONST=0, FWD_X=1, FWD_W=2, FWD_RF=3}.
- One sub-module, pred_pend_cnt: a per-register up/down counter with inc, dec and clr inputs and a cnt output, instantiated NPRED-2 times by generate.

Test Plan:
- Reset: rst_ni low, then issue pRn=0 and pRn=1 -> iss_rdy_o=1, fwd_sel_o=CONST, prfo_o=0 then 1.
- Back-to-back dependency: issue writer pRt1=5/pRt2=6; next cycle issue pRn=5 with no X match -> iss_rdy_o=0. When xpRt1_i=5 & xprfwr_i -> rdy=1, fwd_sel_o=X.
- Writeback: wprfwr_i, wpRt1_i=5, wpRt2_i=6, wpres_i=1 -> next cycle p5=1, p6=0, cnt5=cnt6=0. Reading pRn=6 -> prfo_o=0, fwd_sel_o=RF.
- Saturation: three accepted writers to pRt1=9 with no retire -> fourth writer to 9 gets rdy=0. A same-cycle retire of 9 still stalls. The writer is accepted the next cycle.
- Simultaneous events: accept writer to 7 in the same cycle as retire of 7 with cnt7=1 -> cnt7 stays 1, busy_o=1.
- Flush: cnt nonzero on regs 3 and 12, flush_i with an accepted writer to 20 -> all counters 0, busy_o=0 next cycle. Reading pRn=20 gives rdy=1.
